// File: rtl/cla_seq_adder_ctrl.sv
// Multi-cycle adder/subtractor: one 8-bit carry-lookahead slice is reused
// byte by byte (LSB first) with the inter-slice carry held in a register.
module cla_seq_adder_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NSLICE = WIDTH / 8;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADD  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [IDX_W-1:0] idx;
    logic             carry_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    logic [7:0] a_byte;
    logic [7:0] b_byte;
    logic [7:0] g_byte;
    logic [7:0] p_byte;
    logic [7:0] c_byte;
    logic [7:0] s_byte;

    // Each carry is a flat sum of products of g/p terms, so no carry ripples inside the slice.
    function automatic logic [7:0] cla_carries(input logic [7:0] g, input logic [7:0] p,
                                               input logic ci);
        logic [7:0] c;
        logic       term;
        c = '0;
        for (int i = 0; i < 8; i++) begin
            term = ci;
            for (int k = 0; k <= i; k++) term = term & p[k];
            c[i] = term;
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int k = j + 1; k <= i; k++) term = term & p[k];
                c[i] = c[i] | term;
            end
        end
        return c;
    endfunction

    always_comb begin
        a_byte = '0;
        b_byte = '0;
        for (int i = 0; i < NSLICE; i++) begin
            if (idx == IDX_W'(i)) begin
                a_byte = a_q[8*i +: 8];
                b_byte = b_q[8*i +: 8];
            end
        end
        g_byte = a_byte & b_byte;
        p_byte = a_byte ^ b_byte;
        c_byte = cla_carries(g_byte, p_byte, carry_q);
        s_byte = p_byte ^ {c_byte[6:0], carry_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        carry_q <= sub ? 1'b1 : cin;
                        idx     <= '0;
                        state   <= ADD;
                    end
                end
                ADD: begin
                    for (int i = 0; i < NSLICE; i++) begin
                        if (idx == IDX_W'(i)) sum[8*i +: 8] <= s_byte;
                    end
                    carry_q <= c_byte[7];
                    idx     <= idx + IDX_W'(1);
                    if (idx == LAST_IDX) begin
                        cout  <= c_byte[7];
                        ovf   <= c_byte[7] ^ c_byte[6];
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
// Randomized bench for cla_seq_adder_ctrl (WIDTH=32) against a plain-arithmetic
// reference of {cout,sum} = a + (sub ? ~b : b) + (sub ? 1 : cin).
module tb_cla_seq_adder_ctrl;

    localparam int WIDTH  = 32;
    localparam int NSLICE = WIDTH / 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;

    int n_vec = 0;
    int n_err = 0;

    cla_seq_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns {ovf, cout, sum}; overflow from operand/result sign rule.
    function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                               input logic ci, input logic s);
        logic [WIDTH-1:0] yy;
        logic [WIDTH:0]   r;
        logic             o;
        yy = s ? ~y : y;
        r  = {1'b0, x} + {1'b0, yy} + (WIDTH+1)'(s ? 1'b1 : ci);
        o  = (x[WIDTH-1] == yy[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
        return {o, r};
    endfunction

    task automatic scramble_inputs();
        in_valid = 1'($urandom_range(0, 1));
        a        = $urandom;
        b        = $urandom;
        cin      = 1'($urandom_range(0, 1));
        sub      = 1'($urandom_range(0, 1));
    endtask

    // Called #1 after a rising edge with the controller idle.
    task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                          input logic ci, input logic s, input int hold, input bit noisy);
        logic [WIDTH+1:0] e;
        int               lat;
        e = model(x, y, ci, s);
        lat = 0;
        while (!in_ready && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("in_ready_idle", in_ready, 1);
        a = x; b = y; cin = ci; sub = s; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (noisy) scramble_inputs();
        lat = 0;
        while (!out_valid && lat < NSLICE + 8) begin
            if (noisy) out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            lat++;
            if (noisy) scramble_inputs();
        end
        check("latency", lat, NSLICE);
        check("out_valid", out_valid, 1);
        check("sum", sum, e[WIDTH-1:0]);
        check("cout", cout, e[WIDTH]);
        check("ovf", ovf, e[WIDTH+1]);
        out_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            if (noisy) scramble_inputs();
            @(posedge clk); #1;
            check("hold_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
            check("hold_sum", {ovf, cout, sum}, e);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("post_hs_valid", out_valid, 0);
        check("post_hs_busy", busy, 0);
        out_ready = 1'b0;
        in_valid  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout_ovf", {cout, ovf}, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 0, 1'b0);
        run_op(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1, 1'b0);
        run_op(32'h00000005, 32'h00000007, 1'b0, 1'b1, 0, 1'b0);
        run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 0, 1'b0);
        run_op(32'h80000000, 32'h00000001, 1'b1, 1'b1, 0, 1'b0);
        // Backpressure with in_valid pulsing while the result waits.
        run_op(32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b0, 3, 1'b1);

        // Abort during slice 2.
        a = 32'hDEADBEEF; b = 32'h01010101; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_sum", sum, 0);
        check("abort_cout_ovf", {cout, ovf}, 0);
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 1);
        @(posedge clk); #1;
        check("abort_hold_ready", in_ready, 1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(32'h00000003, 32'h00000004, 1'b0, 1'b0, 0, 1'b0);

        for (int n = 0; n < 2000; n++) begin
            logic [WIDTH-1:0] ra, rb;
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: ra = 32'hFFFFFFFF;
                1: rb = 32'h80000000;
                2: ra = 32'h7FFFFFFF;
                default: ;
            endcase
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            run_op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
